// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // pc fields are sized for the widest supported address; narrower PCs are zero-extended
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register, flush over stall over load
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q.instr    <= NOP_WORD;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, imem addressing and IF/ID staging with redirect/stall/flush
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]    NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_W-1:0]    imem_rdata,
  input  logic                  pcsrc_e,
  input  logic [ADDR_WIDTH-1:0] pc_target_e,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  output logic [INSTR_W-1:0]    instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic                  misalign_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           fetched_cnt,
  output logic [31:0]           flushed_cnt,
  output logic [31:0]           stalled_cnt
`endif
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc_f;
  logic [ADDR_WIDTH-1:0] pc_plus4_f;
  logic                  booting;
  logic                  ifid_flush;
  if_id_t                ifid_d;
  if_id_t                ifid_q;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + ADDR_WIDTH'(4);
  assign booting    = (state == BOOT);
  // BOOT keeps decode invalid regardless of what execute reports
  assign ifid_flush = booting || flush_d || pcsrc_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f       <= RESET_PC;
      state      <= BOOT;
      misalign_o <= 1'b0;
    end else if (booting) begin
      state <= RUN;
    end else if (pcsrc_e) begin
      pc_f  <= {pc_target_e[ADDR_WIDTH-1:2], 2'b00};
      state <= REDIRECT;
      if (pc_target_e[1:0] != 2'b00) misalign_o <= 1'b1;
    end else begin
      state <= RUN;
      if (!stall_f) pc_f <= pc_plus4_f;
    end
  end

  assign ifid_d.instr    = imem_rdata;
  assign ifid_d.pc       = PC_W'(pc_f);
  assign ifid_d.pc_plus4 = PC_W'(pc_plus4_f);
  assign ifid_d.valid    = 1'b1;

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (ifid_flush),
    .stall (stall_d),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign instr_d    = ifid_q.instr;
  assign pc_d       = ifid_q.pc[ADDR_WIDTH-1:0];
  assign pc_plus4_d = ifid_q.pc_plus4[ADDR_WIDTH-1:0];
  assign valid_d    = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic fetch_evt;
  logic flush_evt;
  logic stall_evt;

  assign fetch_evt = !ifid_flush && !stall_d;
  assign flush_evt = !booting && (flush_d || pcsrc_e);
  assign stall_evt = !booting && stall_f && !pcsrc_e;

  // counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_cnt <= '0;
      flushed_cnt <= '0;
      stalled_cnt <= '0;
    end else begin
      if (fetch_evt && fetched_cnt != 32'hFFFF_FFFF) fetched_cnt <= fetched_cnt + 32'd1;
      if (flush_evt && flushed_cnt != 32'hFFFF_FFFF) flushed_cnt <= flushed_cnt + 32'd1;
      if (stall_evt && stalled_cnt != 32'hFFFF_FFFF) stalled_cnt <= stalled_cnt + 32'd1;
    end
  end
`endif

endmodule
